// File: rtl/hpdcache_repl_pkg.sv
// Shared types for the PLRU replacement-port controller: FSM state encoding
// and default-sized set/way vector typedefs.
package hpdcache_repl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIR_RD = 3'd1,
    ST_SELECT = 3'd2,
    ST_RSP    = 3'd3,
    ST_COMMIT = 3'd4
  } repl_state_e;

  localparam int unsigned REPL_DEF_SETS = 64;
  localparam int unsigned REPL_DEF_WAYS = 4;
  localparam int unsigned REPL_DEF_SETW = $clog2(REPL_DEF_SETS);

  typedef logic [REPL_DEF_SETW-1:0] repl_set_t;
  typedef logic [REPL_DEF_WAYS-1:0] repl_way_t;

endpackage

// File: rtl/hpdcache_repl_if.sv
// Bundle of hit-update, refill, directory and PLRU signals around the
// replacement controller; slave is the controller, master is its environment.
interface hpdcache_repl_if #(
  parameter int unsigned SETW = 6,
  parameter int unsigned WAYS = 4,
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]      updt_valid_i;
  logic [NREQ-1:0]      updt_ready_o;
  logic [NREQ*SETW-1:0] updt_set_i;
  logic [NREQ*WAYS-1:0] updt_way_i;

  logic                 refill_req_valid_i;
  logic                 refill_req_ready_o;
  logic [SETW-1:0]      refill_req_set_i;
  logic                 refill_rsp_valid_o;
  logic                 refill_rsp_ready_i;
  logic [WAYS-1:0]      refill_rsp_way_o;
  logic                 refill_rsp_dirty_o;
  logic                 refill_rsp_err_o;

  logic                 dir_rd_o;
  logic [SETW-1:0]      dir_rd_set_o;
  logic [WAYS-1:0]      dir_valid_i;
  logic [WAYS-1:0]      dir_wb_i;
  logic [WAYS-1:0]      dir_dirty_i;

  logic                 plru_updt_o;
  logic [SETW-1:0]      plru_updt_set_o;
  logic [WAYS-1:0]      plru_updt_way_o;
  logic                 plru_repl_o;
  logic [SETW-1:0]      plru_repl_set_o;
  logic [WAYS-1:0]      plru_repl_way_o;
  logic [WAYS-1:0]      plru_dir_valid_o;
  logic [WAYS-1:0]      plru_dir_wb_o;
  logic [WAYS-1:0]      plru_dir_dirty_o;
  logic [WAYS-1:0]      plru_victim_way_i;

  modport slave (
    input  updt_valid_i, updt_set_i, updt_way_i,
    output updt_ready_o,
    input  refill_req_valid_i, refill_req_set_i, refill_rsp_ready_i,
    output refill_req_ready_o, refill_rsp_valid_o, refill_rsp_way_o,
    output refill_rsp_dirty_o, refill_rsp_err_o,
    output dir_rd_o, dir_rd_set_o,
    input  dir_valid_i, dir_wb_i, dir_dirty_i,
    output plru_updt_o, plru_updt_set_o, plru_updt_way_o,
    output plru_repl_o, plru_repl_set_o, plru_repl_way_o,
    output plru_dir_valid_o, plru_dir_wb_o, plru_dir_dirty_o,
    input  plru_victim_way_i
  );

  modport master (
    output updt_valid_i, updt_set_i, updt_way_i,
    input  updt_ready_o,
    output refill_req_valid_i, refill_req_set_i, refill_rsp_ready_i,
    input  refill_req_ready_o, refill_rsp_valid_o, refill_rsp_way_o,
    input  refill_rsp_dirty_o, refill_rsp_err_o,
    input  dir_rd_o, dir_rd_set_o,
    output dir_valid_i, dir_wb_i, dir_dirty_i,
    input  plru_updt_o, plru_updt_set_o, plru_updt_way_o,
    input  plru_repl_o, plru_repl_set_o, plru_repl_way_o,
    input  plru_dir_valid_o, plru_dir_wb_o, plru_dir_dirty_o,
    output plru_victim_way_i
  );
endinterface

// File: rtl/hpdcache_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the pointer; the pointer
// moves past the winner on a grant and is frozen while en_i is low.
module hpdcache_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
        ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/hpdcache_repl_ctrl.sv
// Shares the PLRU update/replace port between hit-update requesters and a
// single refill requester, sequencing victim selection and replace commit.
module hpdcache_repl_ctrl
  import hpdcache_repl_pkg::*;
#(
  parameter int unsigned SETS = 64,
  parameter int unsigned WAYS = 4,
  parameter int unsigned NREQ = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  hpdcache_repl_if.slave bus
);

  localparam int unsigned SETW = $clog2(SETS);

  repl_state_e     state_q, state_d;
  logic [SETW-1:0] set_q, set_d;
  logic [WAYS-1:0] way_q, way_d;
  logic            dirty_q, dirty_d;
  logic            err_q, err_d;
  logic [NREQ-1:0] gnt;

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    way_d   = way_q;
    dirty_d = dirty_q;
    err_d   = err_q;

    bus.refill_req_ready_o = 1'b0;
    bus.refill_rsp_valid_o = 1'b0;
    bus.refill_rsp_way_o   = '0;
    bus.refill_rsp_dirty_o = 1'b0;
    bus.refill_rsp_err_o   = 1'b0;
    bus.dir_rd_o           = 1'b0;
    bus.dir_rd_set_o       = '0;
    bus.plru_repl_o        = 1'b0;
    bus.plru_repl_set_o    = '0;
    bus.plru_repl_way_o    = '0;
    bus.plru_dir_valid_o   = '0;
    bus.plru_dir_wb_o      = '0;
    bus.plru_dir_dirty_o   = '0;

    case (state_q)
      ST_IDLE: begin
        bus.refill_req_ready_o = 1'b1;
        if (bus.refill_req_valid_i) begin
          set_d   = bus.refill_req_set_i;
          state_d = ST_DIR_RD;
        end
      end
      ST_DIR_RD: begin
        bus.dir_rd_o     = 1'b1;
        bus.dir_rd_set_o = set_q;
        state_d          = ST_SELECT;
      end
      ST_SELECT: begin
        // Directory data arrives this cycle; the PLRU picks the victim from it.
        bus.plru_repl_set_o  = set_q;
        bus.plru_dir_valid_o = bus.dir_valid_i;
        bus.plru_dir_wb_o    = bus.dir_wb_i;
        bus.plru_dir_dirty_o = bus.dir_dirty_i;
        way_d   = bus.plru_victim_way_i;
        dirty_d = |(bus.plru_victim_way_i & bus.dir_valid_i & bus.dir_dirty_i);
        err_d   = ~|bus.plru_victim_way_i;
        state_d = ST_RSP;
      end
      ST_RSP: begin
        bus.refill_rsp_valid_o = 1'b1;
        bus.refill_rsp_way_o   = way_q;
        bus.refill_rsp_dirty_o = dirty_q;
        bus.refill_rsp_err_o   = err_q;
        if (bus.refill_rsp_ready_i) state_d = err_q ? ST_IDLE : ST_COMMIT;
      end
      ST_COMMIT: begin
        bus.plru_repl_o     = 1'b1;
        bus.plru_repl_set_o = set_q;
        bus.plru_repl_way_o = way_q;
        state_d             = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      set_q   <= '0;
      way_q   <= '0;
      dirty_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      dirty_q <= dirty_d;
      err_q   <= err_d;
    end
  end

  // The replace commit owns the PLRU port; updates stall for that cycle.
  hpdcache_rr_arbiter #(.N(int'(NREQ))) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (state_q != ST_COMMIT),
    .req_i (bus.updt_valid_i),
    .gnt_o (gnt)
  );

  assign bus.updt_ready_o = gnt;
  assign bus.plru_updt_o  = |gnt;

  always_comb begin
    bus.plru_updt_set_o = '0;
    bus.plru_updt_way_o = '0;
    for (int r = 0; r < int'(NREQ); r++) begin
      if (gnt[r]) begin
        bus.plru_updt_set_o = bus.plru_updt_set_o | bus.updt_set_i[r*SETW +: SETW];
        bus.plru_updt_way_o = bus.plru_updt_way_o | bus.updt_way_i[r*WAYS +: WAYS];
      end
    end
  end

endmodule

// File: tb/tb_hpdcache_repl_ctrl.sv
// Bench for hpdcache_repl_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked each cycle against a transaction model.
module tb_hpdcache_repl_ctrl;

  localparam int SETS = 64;
  localparam int SETW = 6;
  localparam int WAYS = 4;
  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hpdcache_repl_if #(.SETW(SETW), .WAYS(WAYS), .NREQ(NREQ)) bus ();

  hpdcache_repl_ctrl #(.SETS(SETS), .WAYS(WAYS), .NREQ(NREQ)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // staged stimulus, applied on the falling edge
  logic                 t_rst;
  logic [NREQ-1:0]      t_uv;
  logic [NREQ*SETW-1:0] t_us;
  logic [NREQ*WAYS-1:0] t_uw;
  logic                 t_rv, t_rr;
  logic [SETW-1:0]      t_rs;
  logic [WAYS-1:0]      t_dv, t_dwb, t_dd, t_vic;

  // transaction-level model
  int              cyc, m_acc, m_racc, m_ptr;
  bit              m_busy, m_rdone, m_dirty, m_err, chk_en;
  logic [SETW-1:0] m_set;
  logic [WAYS-1:0] m_way;

  int n_chk = 0;
  int n_err = 0;
  int cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    bit dirrd, sel, rsp, commit;
    int w, idx;
    logic [NREQ-1:0] eg;
    logic [SETW-1:0] eus;
    logic [WAYS-1:0] euw;
    @(negedge clk);
    rst                    = t_rst;
    bus.updt_valid_i       = t_uv;
    bus.updt_set_i         = t_us;
    bus.updt_way_i         = t_uw;
    bus.refill_req_valid_i = t_rv;
    bus.refill_req_set_i   = t_rs;
    bus.refill_rsp_ready_i = t_rr;
    bus.dir_valid_i        = t_dv;
    bus.dir_wb_i           = t_dwb;
    bus.dir_dirty_i        = t_dd;
    bus.plru_victim_way_i  = t_vic;
    #1;
    dirrd  = m_busy && (cyc == m_acc + 1);
    sel    = m_busy && (cyc == m_acc + 2);
    rsp    = m_busy && (cyc >= m_acc + 3) && !m_rdone;
    commit = m_busy && m_rdone && (cyc == m_racc + 1);
    w = -1;
    if (!commit)
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && t_uv[idx]) w = idx;
      end
    eg  = (w >= 0) ? NREQ'(1) << w : '0;
    eus = (w >= 0) ? t_us[w*SETW +: SETW] : '0;
    euw = (w >= 0) ? t_uw[w*WAYS +: WAYS] : '0;
    if (chk_en) begin
      chk("req_ready", 32'(bus.refill_req_ready_o), 32'(!m_busy));
      chk("dir_rd", 32'(bus.dir_rd_o), 32'(dirrd));
      chk("dir_rd_set", 32'(bus.dir_rd_set_o), 32'(dirrd ? m_set : '0));
      chk("rsp_valid", 32'(bus.refill_rsp_valid_o), 32'(rsp));
      chk("rsp_way", 32'(bus.refill_rsp_way_o), 32'(rsp ? m_way : '0));
      chk("rsp_dirty", 32'(bus.refill_rsp_dirty_o), 32'(rsp && m_dirty));
      chk("rsp_err", 32'(bus.refill_rsp_err_o), 32'(rsp && m_err));
      chk("plru_repl", 32'(bus.plru_repl_o), 32'(commit));
      chk("plru_repl_set", 32'(bus.plru_repl_set_o), 32'((sel || commit) ? m_set : '0));
      chk("plru_repl_way", 32'(bus.plru_repl_way_o), 32'(commit ? m_way : '0));
      chk("plru_dir_valid", 32'(bus.plru_dir_valid_o), 32'(sel ? t_dv : '0));
      chk("plru_dir_wb", 32'(bus.plru_dir_wb_o), 32'(sel ? t_dwb : '0));
      chk("plru_dir_dirty", 32'(bus.plru_dir_dirty_o), 32'(sel ? t_dd : '0));
      chk("updt_ready", 32'(bus.updt_ready_o), 32'(eg));
      chk("plru_updt", 32'(bus.plru_updt_o), 32'(w >= 0));
      chk("plru_updt_set", 32'(bus.plru_updt_set_o), 32'(eus));
      chk("plru_updt_way", 32'(bus.plru_updt_way_o), 32'(euw));
    end
    if (t_rst) begin
      m_busy = 1'b0;
      m_ptr  = 0;
    end else begin
      if (!m_busy && t_rv) begin
        m_busy = 1'b1; m_acc = cyc; m_set = t_rs; m_rdone = 1'b0;
      end else if (sel) begin
        m_way   = t_vic;
        m_dirty = |(t_vic & t_dv & t_dd);
        m_err   = (t_vic == '0);
      end else if (rsp && t_rr) begin
        m_rdone = 1'b1; m_racc = cyc;
        if (m_err) m_busy = 1'b0;
      end else if (commit) begin
        m_busy = 1'b0;
      end
      if (w >= 0) m_ptr = (w + 1) % NREQ;
    end
    cyc++;
  endtask

  task automatic quiet();
    t_rst = 0; t_uv = '0; t_us = '0; t_uw = '0; t_rv = 0; t_rr = 0; t_rs = '0;
    t_dv = '0; t_dwb = '0; t_dd = '0; t_vic = '0;
  endtask

  initial begin
    cyc = 0; m_acc = 0; m_racc = 0; m_ptr = 0;
    m_busy = 0; m_rdone = 0; m_dirty = 0; m_err = 0; m_set = '0; m_way = '0;
    chk_en = 0;
    quiet();
    t_rst = 1;
    tick(); tick();
    chk_en = 1;
    t_rst = 0;

    // idle after reset
    tick();
    chk("lit_reset_ready", 32'(bus.refill_req_ready_o), 32'd1);
    chk("lit_reset_rsp", 32'(bus.refill_rsp_valid_o), 32'd0);
    chk("lit_reset_updt", 32'(bus.updt_ready_o), 32'd0);

    // both updaters, no refill: 01,10,01,10
    t_uv = 2'b11; t_us = {6'd9, 6'd3}; t_uw = {4'b1000, 4'b0001};
    tick(); chk("lit_rr0", 32'(bus.updt_ready_o), 32'h1);
    chk("lit_rr0_set", 32'(bus.plru_updt_set_o), 32'd3);
    tick(); chk("lit_rr1", 32'(bus.updt_ready_o), 32'h2);
    chk("lit_rr1_way", 32'(bus.plru_updt_way_o), 32'h8);
    tick(); chk("lit_rr2", 32'(bus.updt_ready_o), 32'h1);
    tick(); chk("lit_rr3", 32'(bus.updt_ready_o), 32'h2);

    // same load during a refill: commit cycle stalls updates
    t_rv = 1; t_rs = 6'd20;
    tick(); chk("lit_rf_g0", 32'(bus.updt_ready_o), 32'h1);
    t_rv = 0;
    tick(); chk("lit_rf_g1", 32'(bus.updt_ready_o), 32'h2);
    t_dv = 4'hF; t_vic = 4'b1000;
    tick(); chk("lit_rf_g2", 32'(bus.updt_ready_o), 32'h1);
    t_rr = 1;
    tick(); chk("lit_rf_g3", 32'(bus.updt_ready_o), 32'h2);
    t_rr = 0;
    tick(); chk("lit_rf_commit_rdy", 32'(bus.updt_ready_o), 32'h0);
    chk("lit_rf_commit_updt", 32'(bus.plru_updt_o), 32'd0);
    chk("lit_rf_commit", 32'(bus.plru_repl_o), 32'd1);
    tick(); chk("lit_rf_g5", 32'(bus.updt_ready_o), 32'h1);
    quiet();

    // refill set 5, victim 0100, clean
    t_rv = 1; t_rs = 6'd5;
    tick(); chk("lit_t2_ready", 32'(bus.refill_req_ready_o), 32'd1);
    t_rv = 0;
    tick(); chk("lit_t2_dir_rd", 32'(bus.dir_rd_o), 32'd1);
    chk("lit_t2_dir_set", 32'(bus.dir_rd_set_o), 32'd5);
    t_dv = 4'hF; t_dd = 4'h0; t_vic = 4'b0100;
    tick(); chk("lit_t2_sel_set", 32'(bus.plru_repl_set_o), 32'd5);
    t_rr = 1; t_vic = 4'b0001;
    tick(); chk("lit_t2_rsp", 32'(bus.refill_rsp_valid_o), 32'd1);
    chk("lit_t2_way", 32'(bus.refill_rsp_way_o), 32'h4);
    chk("lit_t2_dirty", 32'(bus.refill_rsp_dirty_o), 32'd0);
    chk("lit_t2_err", 32'(bus.refill_rsp_err_o), 32'd0);
    t_rr = 0;
    tick(); chk("lit_t2_repl", 32'(bus.plru_repl_o), 32'd1);
    chk("lit_t2_repl_set", 32'(bus.plru_repl_set_o), 32'd5);
    chk("lit_t2_repl_way", 32'(bus.plru_repl_way_o), 32'h4);
    tick(); chk("lit_t2_idle", 32'(bus.refill_req_ready_o), 32'd1);
    quiet();

    // dirty victim, consumer stalls 4 cycles
    t_rv = 1; t_rs = 6'd12;
    tick(); t_rv = 0;
    tick(); t_dv = 4'hF; t_dd = 4'b0010; t_vic = 4'b0010;
    tick(); quiet();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lit_t3_hold_v", 32'(bus.refill_rsp_valid_o), 32'd1);
      chk("lit_t3_hold_way", 32'(bus.refill_rsp_way_o), 32'h2);
      chk("lit_t3_hold_dirty", 32'(bus.refill_rsp_dirty_o), 32'd1);
    end
    t_rr = 1;
    tick(); t_rr = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); cnt += int'(bus.plru_repl_o); end
    chk("lit_t3_one_commit", 32'(cnt), 32'd1);

    // no eligible victim
    t_rv = 1; t_rs = 6'd33;
    tick(); t_rv = 0;
    tick(); t_dv = 4'hF; t_vic = 4'b0000;
    tick(); quiet(); t_rr = 1;
    tick(); chk("lit_t4_err", 32'(bus.refill_rsp_err_o), 32'd1);
    chk("lit_t4_way", 32'(bus.refill_rsp_way_o), 32'h0);
    t_rr = 0;
    tick(); chk("lit_t4_no_repl", 32'(bus.plru_repl_o), 32'd0);
    chk("lit_t4_idle", 32'(bus.refill_req_ready_o), 32'd1);

    // reset while the response is pending
    t_rv = 1; t_rs = 6'd40;
    tick(); t_rv = 0;
    tick(); t_dv = 4'hF; t_vic = 4'b0001;
    tick(); quiet(); t_rst = 1;
    tick(); chk("lit_t6_rsp_before", 32'(bus.refill_rsp_valid_o), 32'd1);
    t_rst = 0; t_rr = 1;
    tick(); chk("lit_t6_rsp_dropped", 32'(bus.refill_rsp_valid_o), 32'd0);
    chk("lit_t6_idle", 32'(bus.refill_req_ready_o), 32'd1);
    t_rr = 0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); cnt += int'(bus.plru_repl_o); end
    chk("lit_t6_no_commit", 32'(cnt), 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      t_rst = ($urandom_range(0, 199) == 0);
      t_uv  = NREQ'($urandom);
      t_us  = (NREQ*SETW)'($urandom);
      for (int r = 0; r < NREQ; r++) t_uw[r*WAYS +: WAYS] = WAYS'(1) << $urandom_range(0, WAYS-1);
      t_rv  = ($urandom_range(0, 2) == 0);
      t_rs  = SETW'($urandom);
      t_rr  = $urandom_range(0, 1) == 1;
      t_dv  = WAYS'($urandom);
      t_dwb = WAYS'($urandom);
      t_dd  = WAYS'($urandom);
      t_vic = ($urandom_range(0, 7) == 0) ? '0 : WAYS'(1) << $urandom_range(0, WAYS-1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
